// File: rtl/miss_fill_ctrl_if.sv
// Cache-miss, backing-memory read and fill-return signals of miss_fill_ctrl.
// The controller uses the slave modport; the cache/memory side uses master.
interface miss_fill_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              miss_valid;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_ready;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              fill_err;
  logic              fill_ready;
  logic              busy;

  modport master (
    output miss_valid, miss_addr, mem_rvalid, mem_rdata, fill_ready,
    input  miss_ready, mem_rd_en, mem_addr, fill_valid, fill_addr, fill_data, fill_err, busy
  );

  modport slave (
    input  miss_valid, miss_addr, mem_rvalid, mem_rdata, fill_ready,
    output miss_ready, mem_rd_en, mem_addr, fill_valid, fill_addr, fill_data, fill_err, busy
  );
endinterface

// File: rtl/miss_fill_ctrl.sv
// Cache miss handler: queues miss addresses in a 2-deep FIFO, reads each one from
// backing memory in order and returns one fill per miss (error fill on timeout).
module miss_fill_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  miss_fill_ctrl_if.slave bus
);
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fifo_q [DEPTH];
  logic [ADDR_W-1:0] fifo_d [DEPTH];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;
  logic              fill_err_q, fill_err_d;
  logic              miss_ready_q, miss_ready_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic              fill_valid_q, fill_valid_d;
  logic              busy_q, busy_d;
  logic              push, pop;

  // Next-state: FIFO bookkeeping, request sequencing and registered output values.
  always_comb begin
    state_d     = state_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    timer_d     = timer_q;
    cur_addr_d  = cur_addr_q;
    fill_data_d = fill_data_q;
    fill_err_d  = fill_err_q;

    push = bus.miss_valid && miss_ready_q;
    pop  = (state_q == S_IDLE) && (count_q != '0);

    if (push) begin
      fifo_d[wr_ptr_q] = bus.miss_addr;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cur_addr_d = fifo_q[rd_ptr_q];
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response on the last timer cycle still wins over the timeout.
        if (bus.mem_rvalid) begin
          fill_data_d = bus.mem_rdata;
          fill_err_d  = 1'b0;
          state_d     = S_FILL;
        end else if (timer_q == TMR_LAST) begin
          fill_data_d = '0;
          fill_err_d  = 1'b1;
          state_d     = S_FILL;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_FILL: begin
        if (fill_valid_q && bus.fill_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    miss_ready_d = (count_d < CNT_W'(DEPTH));
    busy_d       = (state_d != S_IDLE) || (count_d != '0);
    mem_rd_en_d  = (state_d == S_REQ);
    fill_valid_d = (state_d == S_FILL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      fifo_q       <= '{default: '0};
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= '0;
      timer_q      <= '0;
      cur_addr_q   <= '0;
      fill_data_q  <= '0;
      fill_err_q   <= 1'b0;
      miss_ready_q <= 1'b1;
      mem_rd_en_q  <= 1'b0;
      fill_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      cur_addr_q   <= cur_addr_d;
      fill_data_q  <= fill_data_d;
      fill_err_q   <= fill_err_d;
      miss_ready_q <= miss_ready_d;
      mem_rd_en_q  <= mem_rd_en_d;
      fill_valid_q <= fill_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.miss_ready = miss_ready_q;
  assign bus.mem_rd_en  = mem_rd_en_q;
  assign bus.mem_addr   = cur_addr_q;
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_addr  = cur_addr_q;
  assign bus.fill_data  = fill_data_q;
  assign bus.fill_err   = fill_err_q;
  assign bus.busy       = busy_q;
endmodule

// File: doc/miss_fill_ctrl.md
MISS_FILL_CTRL -- requirements
Module: miss_fill_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, address width of cache lookups and memory requests.
REQ-002 Parameter DATA_W, default 8, data width of the memory word and the fill word.
REQ-003 Parameter TIMEOUT, default 15, number of WAIT cycles without mem_rvalid before an error fill is issued.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low; rst=0 resets, rst=1 runs.
REQ-006 miss_valid  input  1  cache presents a miss address.
REQ-007 miss_addr  input  ADDR_W  address that missed in the cache.
REQ-008 miss_ready  output  1  block can accept a miss this cycle.
REQ-009 mem_rd_en  output  1  one-cycle read strobe to backing memory.
REQ-010 mem_addr  output  ADDR_W  read address to backing memory.
REQ-011 mem_rvalid  input  1  backing memory read data valid.
REQ-012 mem_rdata  input  DATA_W  backing memory read data.
REQ-013 fill_valid  output  1  fill word presented to the cache.
REQ-014 fill_addr  output  ADDR_W  address of the fill word.
REQ-015 fill_data  output  DATA_W  fill word.
REQ-016 fill_err  output  1  fill produced by timeout; fill_data is 0.
REQ-017 fill_ready  input  1  cache has taken the fill word.
REQ-018 busy  output  1  state is not IDLE, or the queue is non-empty.

Function
REQ-019 A 2-entry FIFO queues miss addresses; a push occurs on any rising edge with miss_valid=1 and miss_ready=1.
REQ-020 miss_ready is high when the registered FIFO count is below 2, and is derived from registered state only.
REQ-021 The FIFO has no bypass: an entry becomes poppable one edge after its push.
REQ-022 Push and pop may occur on the same edge; the count is then unchanged and order is preserved.
REQ-023 The FSM has 4 states: IDLE, REQ, WAIT, FILL.
REQ-024 IDLE with count>0: pop the head into cur_addr on the edge, then go to REQ; IDLE with count=0: stay in IDLE.
REQ-025 REQ: mem_rd_en=1 and mem_addr=cur_addr for exactly one cycle, then go to WAIT with the timer cleared to 0.
REQ-026 mem_rd_en is 0 in all states other than REQ; mem_addr holds cur_addr at all times.
REQ-027 WAIT with mem_rvalid=1: capture mem_rdata, set fill_err=0, go to FILL.
REQ-028 WAIT with mem_rvalid=0: increment the timer.
REQ-029 When the timer equals TIMEOUT-1 and mem_rvalid=0, go to FILL with fill_data=0 and fill_err=1.
REQ-030 mem_rvalid is ignored outside WAIT.
REQ-031 FILL: fill_valid=1 with fill_addr=cur_addr; fill_data and fill_err are held stable until fill_ready=1 is sampled.
REQ-032 When fill_valid and fill_ready are both 1 at an edge, the FSM returns to IDLE and fill_valid drops the next cycle.
REQ-033 Latency: for a miss accepted at edge N, with count=0 and the FSM in IDLE, mem_rd_en is high between edges N+1 and N+2.
REQ-034 With mem_rvalid high at edge N+3, fill_valid is high from edge N+3.
REQ-035 Misses are processed strictly in acceptance order.
REQ-036 Duplicate addresses are not merged; each accepted miss produces exactly one fill.
REQ-037 Misses continue to be queued while the FSM is in REQ, WAIT or FILL.

Reset
REQ-038 On rst=0, asynchronously: state=IDLE, FIFO count=0, timer=0, cur_addr=0.
REQ-039 On rst=0, asynchronously: mem_rd_en=0, mem_addr=0, fill_valid=0, fill_addr=0, fill_data=0, fill_err=0, busy=0; miss_ready=1.
REQ-040 A reset during WAIT or FILL discards the in-flight request and the queued entries.
REQ-041 A mem_rvalid arriving after reset deassertion, while in IDLE, has no effect.

Verification
REQ-042 Single miss: addr 0x0A at edge N, memory returns 0x5A at N+3, fill_ready=1 -> mem_rd_en pulses once with mem_addr=0x0A; fill_addr=0x0A, fill_data=0x5A, fill_err=0 at N+3; busy=0 after the handshake.
REQ-043 Back-pressure: three misses 0x0B, 0x0C, 0x0D on consecutive edges while the first is in WAIT -> miss_ready=0 when the queue holds 2; fills appear in order 0x0B, 0x0C, 0x0D, one each.
REQ-044 Timeout: miss 0x10, mem_rvalid held 0 -> fill_valid with fill_err=1 and fill_data=0 exactly TIMEOUT cycles after the REQ cycle; a late mem_rvalid is ignored.
REQ-045 Fill stall: fill_ready held 0 for 5 cycles -> fill_valid, fill_addr, fill_data stable for all 5; no new mem_rd_en until the handshake.
REQ-046 Reset mid-WAIT: rst=0 while waiting on 0x12 with one queued entry -> outputs return to reset values immediately; no fill is produced after rst=1.
REQ-047 Duplicate: miss 0x0C accepted twice -> two mem_rd_en pulses and two fills.
